// File: rtl/regfile_pkg.sv
// Shared register-file types used by the writeback arbiter and its helpers.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] reg_data_t;

    typedef enum logic {ARB, LOCKED} wb_arb_state_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after start, with wrap.
module rr_pick
    import regfile_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    // Walk from the farthest candidate back to start so the nearest request wins.
    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(start) + k;
            if (j >= N) j = j - N;
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register bank write port, with burst lock.
// Optional macro REGFILE_WB_ARB_ZERO_SUPPRESS_EN drops writes to x0 at the output stage.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = REG_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      wb_hold,
    output logic [ADDR_W-1:0]         write_reg,
    output logic [DATA_W-1:0]         write_data,
    output logic                      write_enable,
    output logic [IDX_W-1:0]          grant_id
);

    wb_arb_state_t      state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   lock_owner;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   acc_idx;
    logic [NUM_REQ-1:0] pick_grant;
    logic [NUM_REQ-1:0] owner_mask;
    logic               accept;
    logic               beat_we;
    logic [ADDR_W-1:0]  sel_reg;
    logic [DATA_W-1:0]  sel_data;

    rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
        .req   (req_valid),
        .start (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // While locked only the burst owner can be accepted; others are starved on purpose.
    always_comb begin
        owner_mask = NUM_REQ'(1) << lock_owner;
        req_ready  = '0;
        if (rst_n && !wb_hold) begin
            req_ready = (state == LOCKED) ? (owner_mask & req_valid) : pick_grant;
        end
    end

    assign accept   = |(req_valid & req_ready);
    assign acc_idx  = (state == LOCKED) ? lock_owner : pick_idx;
    assign sel_reg  = req_reg[acc_idx*ADDR_W +: ADDR_W];
    assign sel_data = req_data[acc_idx*DATA_W +: DATA_W];

`ifdef REGFILE_WB_ARB_ZERO_SUPPRESS_EN
    assign beat_we = |sel_reg;
`else
    assign beat_we = 1'b1;
`endif

    // Hold gates req_ready, so no accept happens and all arbitration state freezes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_enable <= 1'b0;
            write_reg    <= '0;
            write_data   <= '0;
            grant_id     <= '0;
            rr_ptr       <= '0;
            lock_owner   <= '0;
            state        <= ARB;
        end else if (accept) begin
            write_enable <= beat_we;
            write_reg    <= sel_reg;
            write_data   <= sel_data;
            grant_id     <= acc_idx;
            if (state == ARB) begin
                rr_ptr <= (acc_idx == IDX_W'(NUM_REQ - 1)) ? '0 : acc_idx + 1'b1;
                if (req_lock[acc_idx]) begin
                    state      <= LOCKED;
                    lock_owner <= acc_idx;
                end
            end else if (!req_lock[acc_idx]) begin
                state <= ARB;
            end
        end else begin
            write_enable <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reference arbiter model plus a scoreboard of expected write beats.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_lock = '0;
    logic [N*AW-1:0] req_reg = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            wb_hold = 1'b0;
    logic [AW-1:0]   write_reg;
    logic [DW-1:0]   write_data;
    logic            write_enable;
    logic [1:0]      grant_id;

    regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_lock     (req_lock),
        .req_reg      (req_reg),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .wb_hold      (wb_hold),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .write_enable (write_enable),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic      we;
        reg_addr_t r;
        reg_data_t d;
        logic [1:0] id;
    } beat_t;

    beat_t      exp_q[$];
    logic [1:0] glog[$];
    int         errors = 0;
    int         checks = 0;
    reg_addr_t  cur_reg[N];
    reg_data_t  cur_data[N];
    logic [1:0] m_ptr = '0;
    logic [1:0] m_owner = '0;
    logic       m_locked = 1'b0;
`ifdef REGFILE_WB_ARB_ZERO_SUPPRESS_EN
    logic       zs = 1'b1;
`else
    logic       zs = 1'b0;
`endif

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [N-1:0] model_ready(input logic [N-1:0] valid, input logic hold);
        int j;
        if (hold) return '0;
        if (m_locked) return valid & (N'(1) << m_owner);
        for (int k = 0; k < N; k++) begin
            j = (int'(m_ptr) + k) % N;
            if (valid[j]) return N'(1) << j;
        end
        return '0;
    endfunction

    task automatic checkOutput();
        beat_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("write_enable", write_enable, e.we);
            if (e.we) begin
                check_val("write_reg", write_reg, e.r);
                check_val("write_data", write_data, e.d);
                check_val("grant_id", grant_id, e.id);
                glog.push_back(grant_id);
            end
        end else begin
            check_val("idle write_enable", write_enable, 1'b0);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] lock, input logic hold);
        logic [N-1:0] er;
        int a;
        beat_t b;
        for (int i = 0; i < N; i++) begin
            req_reg[i*AW +: AW]  = cur_reg[i];
            req_data[i*DW +: DW] = cur_data[i];
        end
        req_valid = valid;
        req_lock  = lock;
        wb_hold   = hold;
        #1;
        er = model_ready(valid, hold);
        check_val("req_ready", req_ready, er);
        if (er != '0) begin
            a = 0;
            for (int i = 0; i < N; i++) if (er[i]) a = i;
            b.we = !(zs && cur_reg[a] == '0);
            b.r  = cur_reg[a];
            b.d  = cur_data[a];
            b.id = 2'(a);
            exp_q.push_back(b);
            if (!m_locked) begin
                m_ptr = (a == N - 1) ? 2'd0 : 2'(a + 1);
                if (lock[a]) begin
                    m_locked = 1'b1;
                    m_owner  = 2'(a);
                end
            end else if (!lock[a]) begin
                m_locked = 1'b0;
            end
            cur_reg[a]  = cur_reg[a] + 5'd1;
            cur_data[a] = cur_data[a] + 32'h0001_0001;
        end
    endtask

    task automatic step(input logic [N-1:0] valid, input logic [N-1:0] lock, input logic hold);
        @(negedge clk);
        checkOutput();
        applyStimulus(valid, lock, hold);
    endtask

    initial begin
        logic [1:0] exp_seq[$];
        for (int i = 0; i < N; i++) begin
            cur_reg[i]  = 5'(i * 8 + 1);
            cur_data[i] = 32'hA000_0000 + 32'(i) * 32'h0100_0000;
        end

        // Reset values, with requests pending so req_ready gating is visible.
        req_valid = 3'b111;
        #12;
        check_val("reset write_enable", write_enable, 1'b0);
        check_val("reset write_reg", write_reg, '0);
        check_val("reset write_data", write_data, '0);
        check_val("reset grant_id", grant_id, '0);
        check_val("reset req_ready", req_ready, '0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // All three valid continuously: strict rotation 0,1,2,0,1,2.
        glog.delete();
        repeat (6) step(3'b111, 3'b000, 1'b0);
        step(3'b000, 3'b000, 1'b0);
        exp_seq = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
        check_val("rotation count", glog.size(), 6);
        for (int i = 0; i < 6 && i < glog.size(); i++) check_val("rotation id", glog[i], exp_seq[i]);

        // Lone requester 1 with reg 7 / 0xDEADBEEF.
        cur_reg[1]  = 5'd7;
        cur_data[1] = 32'hDEAD_BEEF;
        step(3'b010, 3'b000, 1'b0);
        check_val("lone ready", req_ready, 3'b010);
        @(negedge clk);
        check_val("lone write_reg", write_reg, 5'd7);
        check_val("lone write_data", write_data, 32'hDEAD_BEEF);
        check_val("lone grant_id", grant_id, 2'd1);
        checkOutput();
        applyStimulus(3'b000, 3'b000, 1'b0);

        // Requester 2 locked burst with a valid gap; 0 and 1 stay valid.
        glog.delete();
        step(3'b111, 3'b100, 1'b0);
        step(3'b011, 3'b100, 1'b0);
        check_val("gap no grant", req_ready, 3'b000);
        step(3'b111, 3'b100, 1'b0);
        step(3'b111, 3'b000, 1'b0);
        step(3'b011, 3'b000, 1'b0);
        step(3'b011, 3'b000, 1'b0);
        step(3'b000, 3'b000, 1'b0);
        exp_seq = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd1};
        check_val("burst count", glog.size(), 5);
        for (int i = 0; i < 5 && i < glog.size(); i++) check_val("burst id", glog[i], exp_seq[i]);

        // Hold for 4 cycles: one drain write, no accepts, resume from frozen pointer.
        step(3'b011, 3'b000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(3'b111, 3'b000, 1'b1);
            check_val("hold ready", req_ready, 3'b000);
        end
        glog.delete();
        step(3'b111, 3'b000, 1'b0);
        step(3'b000, 3'b000, 1'b0);
        check_val("resume count", glog.size(), 1);
        if (glog.size() > 0) check_val("resume id", glog[0], 2'd1);

        // Reset asserted mid-burst while a beat is on the output.
        step(3'b001, 3'b001, 1'b0);
        step(3'b001, 3'b001, 1'b0);
        @(posedge clk);
        #2;
        check_val("pre-reset write_enable", write_enable, 1'b1);
        rst_n = 1'b0;
        #1;
        check_val("async write_enable", write_enable, 1'b0);
        check_val("async write_reg", write_reg, '0);
        check_val("async write_data", write_data, '0);
        check_val("async grant_id", grant_id, '0);
        check_val("async req_ready", req_ready, '0);
        exp_q.delete();
        m_ptr    = '0;
        m_locked = 1'b0;
        m_owner  = '0;
        req_valid = '0;
        req_lock  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        glog.delete();
        repeat (3) step(3'b111, 3'b000, 1'b0);
        step(3'b000, 3'b000, 1'b0);
        exp_seq = '{2'd0, 2'd1, 2'd2};
        check_val("post-reset count", glog.size(), 3);
        for (int i = 0; i < 3 && i < glog.size(); i++) check_val("post-reset id", glog[i], exp_seq[i]);

        // Write to x0: suppressed only when the zero-suppress build is selected.
        cur_reg[0]  = 5'd0;
        cur_data[0] = 32'h1234_5678;
        step(3'b001, 3'b000, 1'b0);
        check_val("x0 accepted", req_ready, 3'b001);
        @(negedge clk);
        check_val("x0 write_enable", write_enable, !zs);
        checkOutput();
        applyStimulus(3'b000, 3'b000, 1'b0);

        step(3'b000, 3'b000, 1'b0);
        check_val("scoreboard empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
